// File: rtl/data_memory_ls_if.sv
// Load/store bus between the core's memory stage and the data memory.
interface data_memory_ls_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req;
  logic                     we;
  logic [2:0]               funct3;
  logic [ADDRESS_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0]    WD;
  logic                     ready;
  logic [DATA_WIDTH-1:0]    RD;
  logic                     rvalid;
  logic                     err;

  modport master (output req, we, funct3, A, WD, input ready, RD, rvalid, err);
  modport slave  (input req, we, funct3, A, WD, output ready, RD, rvalid, err);
endinterface

// File: rtl/data_memory_ls.sv
// Byte-addressable RV32 data memory: sized loads/stores, registered read,
// fault reporting and an optional post-reset clear sweep.
module data_memory_ls_lane #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [IDX_W-1:0] widx,
  input  logic [7:0]       wdata,
  input  logic             ren,
  input  logic [IDX_W-1:0] ridx,
  output logic [7:0]       rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[widx] <= wdata;
    if (ren) rdata <= mem[ridx];
  end
endmodule

module data_memory_ls #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH_WORDS    = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  data_memory_ls_if.slave     bus
);
  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = 4;

  if (DATA_WIDTH != 32) begin : g_bad_dw
    $error("data_memory_ls: DATA_WIDTH must be 32");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("data_memory_ls: DEPTH_WORDS must be a power of two >= 2");
  end

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] clr_ptr, clr_ptr_n;
  logic             clearing;

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             unused_abits;
  assign idx          = bus.A[IDX_W+1:2];
  assign off          = bus.A[1:0];
  assign unused_abits = ^bus.A[ADDRESS_WIDTH-1:IDX_W+2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      clr_ptr <= '0;
    end else begin
      state   <= state_n;
      clr_ptr <= clr_ptr_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_ptr_n = clr_ptr;
    clearing  = 1'b0;
    case (state)
      S_CLEAR: begin
        clearing  = 1'b1;
        clr_ptr_n = clr_ptr + IDX_W'(1);
        if (clr_ptr == IDX_W'(DEPTH_WORDS - 1)) state_n = S_READY;
      end
      default: ;
    endcase
  end

  assign bus.ready = (state == S_READY);

  // Fault decode; LBU/LHU encodings are illegal for stores.
  logic fault;
  always_comb begin
    fault = 1'b0;
    case (bus.funct3)
      3'b000, 3'b100: fault = bus.we & bus.funct3[2];
      3'b001, 3'b101: fault = off[0] | (bus.we & bus.funct3[2]);
      3'b010:         fault = |off;
      default:        fault = 1'b1;
    endcase
  end

  logic [NUM_LANES-1:0]      mask;
  logic [NUM_LANES-1:0][7:0] wd_lane;
  always_comb begin
    mask    = 4'b1111;
    wd_lane = bus.WD;
    case (bus.funct3[1:0])
      2'd0: begin mask = 4'b0001 << off; wd_lane = {4{bus.WD[7:0]}}; end
      2'd1: begin mask = off[1] ? 4'b1100 : 4'b0011; wd_lane = {2{bus.WD[15:0]}}; end
      default: ;
    endcase
  end

  logic acc, st, ld;
  assign acc = bus.ready & bus.req;
  assign st  = acc & bus.we & ~fault;
  assign ld  = acc & ~bus.we;

  logic [NUM_LANES-1:0][7:0] word_q;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    data_memory_ls_lane #(.DEPTH(DEPTH_WORDS), .IDX_W(IDX_W)) u_lane (
      .clk   (clk),
      .wen   (rst_n & (clearing | (st & mask[i]))),
      .widx  (clearing ? clr_ptr : idx),
      .wdata (clearing ? 8'h00 : wd_lane[i]),
      .ren   (ld),
      .ridx  (idx),
      .rdata (word_q[i])
    );
  end

  logic        vld_q, err_q, ld_q, flt_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] rd_hold, rd_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      flt_q   <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      rd_hold <= '0;
    end else begin
      vld_q <= acc;
      err_q <= acc & fault;
      ld_q  <= ld;
      flt_q <= fault;
      if (ld) begin
        f3_q  <= bus.funct3;
        off_q <= off;
      end
      if (vld_q && ld_q) rd_hold <= rd_sel;
    end
  end

  // Lane select and extension work off the registered word, so RD is
  // valid in the response cycle and then parks in rd_hold.
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  always_comb begin
    sel_b  = word_q[off_q];
    sel_h  = off_q[1] ? {word_q[3], word_q[2]} : {word_q[1], word_q[0]};
    rd_sel = '0;
    if (!flt_q) begin
      case (f3_q)
        3'b000:  rd_sel = {{24{sel_b[7]}}, sel_b};
        3'b001:  rd_sel = {{16{sel_h[15]}}, sel_h};
        3'b010:  rd_sel = word_q;
        3'b100:  rd_sel = {24'h0, sel_b};
        3'b101:  rd_sel = {16'h0, sel_h};
        default: rd_sel = '0;
      endcase
    end
  end

  assign bus.RD     = (vld_q && ld_q) ? rd_sel : rd_hold;
  assign bus.rvalid = vld_q;
  assign bus.err    = err_q;
endmodule
